y_mux_4to1: RTL and testbench
=============================

Y_MUX_4TO1 -- requirements
Module: y_mux_4to1

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the data width of every data input and output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port z, output, SIZE bits: combinational mux result.
REQ-005 The block SHALL have port a0, input, SIZE bits: data selected when c = 0.
REQ-006 The block SHALL have port a1, input, SIZE bits: data selected when c = 1.
REQ-007 The block SHALL have port a2, input, SIZE bits: data selected when c = 2.
REQ-008 The block SHALL have port a3, input, SIZE bits: data selected when c = 3.
REQ-009 The block SHALL have port c, input, 2 bits: select.
REQ-010 The block SHALL have port z_q, output, SIZE bits: registered copy of z.
REQ-011 The block SHALL have port c_q, output, 2 bits: registered copy of c, aligned with z_q.
REQ-012 Positional port order SHALL be z, a0, a1, a2, a3, c, followed by clk, rst_n, z_q, c_q; the first six positions keep the existing 6-port instantiation order.

Function
REQ-013 z SHALL be purely combinational with zero clock latency: c=2'b00 gives a0, 2'b01 gives a1, 2'b10 gives a2, 2'b11 gives a3, bit-for-bit across all SIZE bits.
REQ-014 z SHALL settle within the same simulation timestep as any change on a0..a3 or c, with no explicit delays; a bench may sample z 1 time unit after driving inputs.
REQ-015 Selection SHALL be built as two stages of 2:1 muxing: c[0] picks a0/a1 and a2/a3, then c[1] picks between the two intermediate results.
REQ-016 A 2:1 stage SHALL output its first input when its select is 0 and its second input when 1.
REQ-017 With an X/Z select bit, the affected stage output SHALL follow gate-level AND/OR mux semantics and may be X where the two inputs differ; no special handling is required.
REQ-018 z SHALL depend only on a0..a3 and c; it SHALL NOT depend on clk or rst_n, and reset SHALL NOT affect z.
REQ-019 Except when rst_n is low (REQ-022), on every rising clk edge z_q SHALL load the current z and c_q SHALL load the current c.
REQ-020 Register latency SHALL be exactly one cycle: z_q and c_q reflect the inputs present at the preceding rising edge.
REQ-021 z_q and c_q SHALL hold their values between rising edges regardless of input activity.

Reset
REQ-022 When rst_n is low at a rising clk edge, z_q SHALL become all zeros and c_q SHALL become 2'b00; this takes priority over the load in REQ-019.
REQ-023 Reset SHALL be synchronous only: asserting rst_n between edges SHALL NOT change z_q or c_q until the next rising edge.
REQ-024 On the first rising edge with rst_n high after reset, z_q and c_q SHALL resume loading z and c.
REQ-025 Before the first reset edge, z_q and c_q MAY be X.

Verification
REQ-026 A bench SHALL apply a0=32'h00000001, a1=32'h00000002, a2=32'h00000004, a3=32'h00000008, step c through 0,1,2,3, and require z = 1, 2, 4, 8 respectively 1 time unit after each change.
REQ-027 A bench SHALL run at least 10 random vectors of a0..a3 and c and require z === the selected input 1 time unit after each change, reporting PASS or FAIL per vector with all values.
REQ-028 A bench SHALL set c=3 and change only a3 from 32'hFFFFFFFF to 32'h0, and require z to follow immediately, with no clock edge, while changes on a0..a2 leave z unchanged.
REQ-029 A bench SHALL drive rst_n=0 across one rising edge with z nonzero and require z_q=0 and c_q=0, while z still equals the selected input.
REQ-030 A bench SHALL release reset, apply c=2 and a2=32'hDEADBEEF, and after one rising edge require z_q=32'hDEADBEEF and c_q=2; it SHALL then change the inputs mid-cycle and require z_q to hold until the next edge.
REQ-031 A bench SHALL instantiate the block with SIZE=1 and SIZE=8 and repeat REQ-026 using the inputs masked to SIZE bits.

Source files
------------

// File: rtl/y_mux_4to1.sv
// 4:1 data mux built from two stages of 2:1 muxes, with a registered copy of
// the result and the select that produced it.
module y_mux_4to1 #(
    parameter int unsigned SIZE = 32
) (
    output logic [SIZE-1:0] z,
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    input  logic [1:0]      c,
    input  logic            clk,
    input  logic            rst_n,
    output logic [SIZE-1:0] z_q,
    output logic [1:0]      c_q
);

    logic [SIZE-1:0] lo_sel;
    logic [SIZE-1:0] hi_sel;

    // The ternary merges bitwise on an X select, so bits where both inputs
    // agree stay known and differing bits go X, as a gate-level mux would.
    always_comb begin
        lo_sel = c[0] ? a1 : a0;
        hi_sel = c[0] ? a3 : a2;
        z      = c[1] ? hi_sel : lo_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= '0;
            c_q <= 2'b00;
        end else begin
            z_q <= z;
            c_q <= c;
        end
    end

endmodule

// File: tb/tb_y_mux_4to1.sv
// Directed and random checks of y_mux_4to1 at SIZE 32, 8 and 1, using a queue
// of expected values that is filled when stimulus is driven.
module tb_y_mux_4to1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a0, a1, a2, a3;
    logic [1:0]  c;

    logic [31:0] z32, zq32;
    logic [7:0]  z8, zq8;
    logic [0:0]  z1, zq1;
    logic [1:0]  cq32, cq8, cq1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    y_mux_4to1 #(.SIZE(32)) u_dut32 (
        .z(z32), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .c(c),
        .clk(clk), .rst_n(rst_n), .z_q(zq32), .c_q(cq32)
    );
    y_mux_4to1 #(.SIZE(8)) u_dut8 (
        .z(z8), .a0(a0[7:0]), .a1(a1[7:0]), .a2(a2[7:0]), .a3(a3[7:0]), .c(c),
        .clk(clk), .rst_n(rst_n), .z_q(zq8), .c_q(cq8)
    );
    y_mux_4to1 #(.SIZE(1)) u_dut1 (
        .z(z1), .a0(a0[0:0]), .a1(a1[0:0]), .a2(a2[0:0]), .a3(a3[0:0]), .c(c),
        .clk(clk), .rst_n(rst_n), .z_q(zq1), .c_q(cq1)
    );

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] x0,
                                         input logic [31:0] x1, input logic [31:0] x2,
                                         input logic [31:0] x3);
        case (s)
            2'd0:    return x0;
            2'd1:    return x1;
            2'd2:    return x2;
            default: return x3;
        endcase
    endfunction

    task automatic expect_val(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h but no expected value queued", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Queue the combinational expectation for all three widths, then compare.
    task automatic check_z_all(input string tag);
        logic [31:0] e;
        e = pick(c, a0, a1, a2, a3);
        expect_val(e);
        expect_val({24'd0, e[7:0]});
        expect_val({31'd0, e[0]});
        check_pop({tag, "_z32"}, z32);
        check_pop({tag, "_z8"}, {24'd0, z8});
        check_pop({tag, "_z1"}, {31'd0, z1});
    endtask

    initial begin
        logic [31:0] exp32 [4];
        logic [31:0] exp8  [4];
        logic [31:0] exp1  [4];
        int          fail_before;
        exp32 = '{32'h1, 32'h2, 32'h4, 32'h8};
        exp8  = '{32'h1, 32'h2, 32'h4, 32'h8};
        exp1  = '{32'h1, 32'h0, 32'h0, 32'h0};

        // Reset with z nonzero: registers clear, z keeps following inputs.
        rst_n = 1'b0;
        a0 = 32'h1; a1 = 32'h2; a2 = 32'h4; a3 = 32'h8; c = 2'd2;
        @(posedge clk); #1;
        expect_val(32'h0); check_pop("rst_zq32", zq32);
        expect_val(32'h0); check_pop("rst_cq32", {30'd0, cq32});
        expect_val(32'h0); check_pop("rst_zq8", {24'd0, zq8});
        expect_val(32'h0); check_pop("rst_zq1", {31'd0, zq1});
        expect_val(32'h4); check_pop("rst_z32", z32);

        // One-hot data, select stepped 0..3.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            c = 2'(i);
            #1;
            expect_val(exp32[i]); check_pop($sformatf("onehot%0d_z32", i), z32);
            expect_val(exp8[i]);  check_pop($sformatf("onehot%0d_z8", i), {24'd0, z8});
            expect_val(exp1[i]);  check_pop($sformatf("onehot%0d_z1", i), {31'd0, z1});
        end

        // c=3: z follows a3 with no clock edge; other inputs have no effect.
        @(negedge clk);
        c = 2'd3; a3 = 32'hFFFF_FFFF; #1;
        expect_val(32'hFFFF_FFFF); check_pop("a3_ones", z32);
        a3 = 32'h0; #1;
        expect_val(32'h0); check_pop("a3_zero", z32);
        a0 = 32'hA5A5_A5A5; a1 = 32'h5A5A_5A5A; a2 = 32'h1234_5678; #1;
        expect_val(32'h0); check_pop("others_ignored", z32);

        // Random vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
            c  = 2'($urandom_range(0, 3));
            #1;
            fail_before = n_fail;
            check_z_all($sformatf("rand%0d", i));
            if (n_fail == fail_before)
                $display("PASS rand%0d c=%0d a0=%h a1=%h a2=%h a3=%h z=%h",
                         i, c, a0, a1, a2, a3, z32);
        end

        // Release reset and load a known value.
        @(negedge clk);
        rst_n = 1'b1; c = 2'd2; a2 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        expect_val(32'hDEAD_BEEF); check_pop("load_zq32", zq32);
        expect_val(32'h2);         check_pop("load_cq32", {30'd0, cq32});
        expect_val(32'hEF);        check_pop("load_zq8", {24'd0, zq8});
        expect_val(32'h1);         check_pop("load_zq1", {31'd0, zq1});

        // Mid-cycle input change: registers hold, then load at the next edge.
        @(negedge clk);
        c = 2'd1; a1 = 32'h0BAD_F00D; #1;
        expect_val(32'hDEAD_BEEF); check_pop("hold_zq32", zq32);
        expect_val(32'h2);         check_pop("hold_cq32", {30'd0, cq32});
        @(posedge clk); #1;
        expect_val(32'h0BAD_F00D); check_pop("next_zq32", zq32);
        expect_val(32'h1);         check_pop("next_cq32", {30'd0, cq32});

        // Reset asserted between edges takes effect only at the edge.
        @(negedge clk);
        rst_n = 1'b0; #1;
        expect_val(32'h0BAD_F00D); check_pop("midrst_hold_zq32", zq32);
        expect_val(32'h1);         check_pop("midrst_hold_cq32", {30'd0, cq32});
        @(posedge clk); #1;
        expect_val(32'h0); check_pop("midrst_zq32", zq32);
        expect_val(32'h0); check_pop("midrst_cq32", {30'd0, cq32});
        expect_val(32'h0BAD_F00D); check_pop("midrst_z32", z32);

        // Registered path over random cycles: one-cycle latency at every width.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] e;
            a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
            c  = 2'($urandom_range(0, 3));
            e  = pick(c, a0, a1, a2, a3);
            expect_val(e);
            expect_val({30'd0, c});
            expect_val({24'd0, e[7:0]});
            expect_val({31'd0, e[0]});
            expect_val({30'd0, c});
            @(posedge clk); #1;
            check_pop($sformatf("pipe%0d_zq32", i), zq32);
            check_pop($sformatf("pipe%0d_cq32", i), {30'd0, cq32});
            check_pop($sformatf("pipe%0d_zq8", i), {24'd0, zq8});
            check_pop($sformatf("pipe%0d_zq1", i), {31'd0, zq1});
            check_pop($sformatf("pipe%0d_cq1", i), {30'd0, cq1});
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
